// File: rtl/ovr_i_fault_mon.sv
// ovr_i_fault_mon
// Over-current fault monitor that sits just upstream of the PWM output gating.
// It synchronizes the raw left/right over-current comparator flags and ignores
// them while the delayed blanking window is high. It counts consecutive PWM
// periods that contained a qualified event on each side. When either side
// reaches TRIP_PERIODS it latches a shutdown that forces the PWM outputs low.
//
// Optional build macro: OVR_I_AUTO_RETRY_EN
//   undefined : shutdown exits only via clr_fault or rst.
//   defined   : the shutdown state becomes a retry wait. It returns to run by
//               itself after RETRY_PERIODS PWM periods. The fault flags stay
//               sticky until clr_fault.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   PWM_synch   in   one-cycle pulse at the start of each PWM period
//   ovr_I_blank in   high during the switching blanking window
//   OVR_I_lft   in   raw asynchronous left over-current flag
//   OVR_I_rght  in   raw asynchronous right over-current flag
//   clr_fault   in   one-cycle request to leave shutdown
//   pwm_en      out  1 = PWM allowed, 0 = force all four PWM outputs low
//   fault_lft   out  sticky: left side caused a trip
//   fault_rght  out  sticky: right side caused a trip
//   trip_cnt    out  saturating count of trips since reset
module ovr_i_fault_mon #(
  parameter int unsigned TRIP_PERIODS  = 4,
  parameter int unsigned CNT_W         = 4,
  parameter int unsigned RETRY_PERIODS = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PWM_synch,
  input  logic       ovr_I_blank,
  input  logic       OVR_I_lft,
  input  logic       OVR_I_rght,
  input  logic       clr_fault,
  output logic       pwm_en,
  output logic       fault_lft,
  output logic       fault_rght,
  output logic [7:0] trip_cnt
);

  if (TRIP_PERIODS < 1 || TRIP_PERIODS > 15 || TRIP_PERIODS >= (2 ** CNT_W) ||
      RETRY_PERIODS < 1) begin : g_param_err
    $error("ovr_i_fault_mon: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TripThr = CNT_W'(TRIP_PERIODS);

`ifdef OVR_I_AUTO_RETRY_EN
  typedef enum logic [0:0] {StRun = 1'b0, StRetryWait = 1'b1} state_e;
  localparam state_e StOff = StRetryWait;
  localparam int unsigned RetryW = $clog2(RETRY_PERIODS + 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(RETRY_PERIODS);
`else
  typedef enum logic [0:0] {StRun = 1'b0, StShutdown = 1'b1} state_e;
  localparam state_e StOff = StShutdown;
`endif

  state_e r_state, w_state_d;

  // Two-flop synchronizers; blank gets the same delay to stay aligned.
  logic r_lft_s1, r_lft_s2, r_rght_s1, r_rght_s2, r_blank_d1, r_blank_d2;

  logic             r_seen_lft, r_seen_rght, w_seen_lft_d, w_seen_rght_d;
  logic [CNT_W-1:0] r_cnt_lft, r_cnt_rght, w_cnt_lft_d, w_cnt_rght_d;
  logic [CNT_W-1:0] w_upd_lft, w_upd_rght;
  logic             r_fault_lft, r_fault_rght, w_fault_lft_d, w_fault_rght_d;
  logic [7:0]       r_trip_cnt, w_trip_cnt_d;
  logic             w_q_lft, w_q_rght, w_trip_lft, w_trip_rght;

`ifdef OVR_I_AUTO_RETRY_EN
  logic [RetryW-1:0] r_retry_cnt, w_retry_cnt_d, w_retry_inc;
  assign w_retry_inc = r_retry_cnt + RetryW'(1);
`endif

  assign w_q_lft  = r_lft_s2 & ~r_blank_d2;
  assign w_q_rght = r_rght_s2 & ~r_blank_d2;

  // Counter value the closing PWM_synch would produce; a same-cycle event counts.
  always_comb begin
    w_upd_lft  = '0;
    w_upd_rght = '0;
    if (r_seen_lft | w_q_lft) begin
      w_upd_lft = (r_cnt_lft == CntMax) ? r_cnt_lft : r_cnt_lft + CNT_W'(1);
    end
    if (r_seen_rght | w_q_rght) begin
      w_upd_rght = (r_cnt_rght == CntMax) ? r_cnt_rght : r_cnt_rght + CNT_W'(1);
    end
  end

  assign w_trip_lft  = (r_state == StRun) & PWM_synch & (w_upd_lft >= TripThr);
  assign w_trip_rght = (r_state == StRun) & PWM_synch & (w_upd_rght >= TripThr);

  always_comb begin
    w_state_d      = r_state;
    w_seen_lft_d   = r_seen_lft;
    w_seen_rght_d  = r_seen_rght;
    w_cnt_lft_d    = r_cnt_lft;
    w_cnt_rght_d   = r_cnt_rght;
    w_fault_lft_d  = r_fault_lft;
    w_fault_rght_d = r_fault_rght;
    w_trip_cnt_d   = r_trip_cnt;
`ifdef OVR_I_AUTO_RETRY_EN
    w_retry_cnt_d  = r_retry_cnt;
`endif

    case (r_state)
      StRun: begin
        if (PWM_synch) begin
          w_cnt_lft_d   = w_upd_lft;
          w_cnt_rght_d  = w_upd_rght;
          w_seen_lft_d  = 1'b0;
          w_seen_rght_d = 1'b0;
        end else begin
          if (w_q_lft)  w_seen_lft_d  = 1'b1;
          if (w_q_rght) w_seen_rght_d = 1'b1;
        end

        // A trip outranks a coincident clr_fault.
        if (w_trip_lft | w_trip_rght) begin
          w_state_d      = StOff;
          w_fault_lft_d  = r_fault_lft  | w_trip_lft;
          w_fault_rght_d = r_fault_rght | w_trip_rght;
          w_trip_cnt_d   = (r_trip_cnt == 8'hFF) ? r_trip_cnt : r_trip_cnt + 8'd1;
          w_cnt_lft_d    = '0;
          w_cnt_rght_d   = '0;
          w_seen_lft_d   = 1'b0;
          w_seen_rght_d  = 1'b0;
`ifdef OVR_I_AUTO_RETRY_EN
          w_retry_cnt_d  = '0;
`endif
        end else if (clr_fault) begin
          // Only matters after an auto-retry, where the flags are still sticky.
          w_fault_lft_d  = 1'b0;
          w_fault_rght_d = 1'b0;
        end
      end

      StOff: begin
        w_cnt_lft_d   = '0;
        w_cnt_rght_d  = '0;
        w_seen_lft_d  = 1'b0;
        w_seen_rght_d = 1'b0;
        if (clr_fault) begin
          w_state_d      = StRun;
          w_fault_lft_d  = 1'b0;
          w_fault_rght_d = 1'b0;
`ifdef OVR_I_AUTO_RETRY_EN
          w_retry_cnt_d  = '0;
        end else if (PWM_synch) begin
          if (w_retry_inc == RetryMax) begin
            w_state_d     = StRun;
            w_retry_cnt_d = '0;
          end else begin
            w_retry_cnt_d = w_retry_inc;
          end
`endif
        end
      end

      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StRun;
      r_lft_s1     <= 1'b0;
      r_lft_s2     <= 1'b0;
      r_rght_s1    <= 1'b0;
      r_rght_s2    <= 1'b0;
      r_blank_d1   <= 1'b0;
      r_blank_d2   <= 1'b0;
      r_seen_lft   <= 1'b0;
      r_seen_rght  <= 1'b0;
      r_cnt_lft    <= '0;
      r_cnt_rght   <= '0;
      r_fault_lft  <= 1'b0;
      r_fault_rght <= 1'b0;
      r_trip_cnt   <= 8'd0;
`ifdef OVR_I_AUTO_RETRY_EN
      r_retry_cnt  <= '0;
`endif
    end else begin
      r_state      <= w_state_d;
      r_lft_s1     <= OVR_I_lft;
      r_lft_s2     <= r_lft_s1;
      r_rght_s1    <= OVR_I_rght;
      r_rght_s2    <= r_rght_s1;
      r_blank_d1   <= ovr_I_blank;
      r_blank_d2   <= r_blank_d1;
      r_seen_lft   <= w_seen_lft_d;
      r_seen_rght  <= w_seen_rght_d;
      r_cnt_lft    <= w_cnt_lft_d;
      r_cnt_rght   <= w_cnt_rght_d;
      r_fault_lft  <= w_fault_lft_d;
      r_fault_rght <= w_fault_rght_d;
      r_trip_cnt   <= w_trip_cnt_d;
`ifdef OVR_I_AUTO_RETRY_EN
      r_retry_cnt  <= w_retry_cnt_d;
`endif
    end
  end

  assign pwm_en     = (r_state == StRun);
  assign fault_lft  = r_fault_lft;
  assign fault_rght = r_fault_rght;
  assign trip_cnt   = r_trip_cnt;

endmodule

// File: tb/tb_ovr_i_fault_mon.sv
// Directed bench for ovr_i_fault_mon. A PWM period is 120 clks: PWM_synch at
// cycle 0 and blank over cycles 1..60. A "blanked" pulse covers cycles 5..49
// and an "outside" pulse covers cycles 65..109.
module tb_ovr_i_fault_mon;

  logic       clk = 1'b0;
  logic       rst, PWM_synch, ovr_I_blank, OVR_I_lft, OVR_I_rght, clr_fault;
  logic       pwm_en, fault_lft, fault_rght;
  logic [7:0] trip_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ovr_i_fault_mon #(
    .TRIP_PERIODS (4),
    .CNT_W        (4),
    .RETRY_PERIODS(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .PWM_synch  (PWM_synch),
    .ovr_I_blank(ovr_I_blank),
    .OVR_I_lft  (OVR_I_lft),
    .OVR_I_rght (OVR_I_rght),
    .clr_fault  (clr_fault),
    .pwm_en     (pwm_en),
    .fault_lft  (fault_lft),
    .fault_rght (fault_rght),
    .trip_cnt   (trip_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle 0 of a period: the synch pulse, optionally with clr_fault.
  task automatic synch(input bit clr);
    PWM_synch   = 1'b1;
    ovr_I_blank = 1'b0;
    OVR_I_lft   = 1'b0;
    OVR_I_rght  = 1'b0;
    clr_fault   = clr;
    tick();
    PWM_synch   = 1'b0;
    clr_fault   = 1'b0;
  endtask

  // Cycles 1..119. Mode: 0 quiet, 1 pulse inside blank, 2 pulse outside blank.
  task automatic body(input int ml, input int mr);
    for (int c = 1; c < 120; c++) begin
      ovr_I_blank = (c >= 1 && c <= 60);
      OVR_I_lft   = (ml == 1) ? (c >= 5 && c <= 49) : (ml == 2) ? (c >= 65 && c <= 109) : 1'b0;
      OVR_I_rght  = (mr == 1) ? (c >= 5 && c <= 49) : (mr == 2) ? (c >= 65 && c <= 109) : 1'b0;
      tick();
    end
    ovr_I_blank = 1'b0;
    OVR_I_lft   = 1'b0;
    OVR_I_rght  = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
  endtask

  initial begin
    rst = 1'b1; PWM_synch = 1'b0; ovr_I_blank = 1'b0;
    OVR_I_lft = 1'b0; OVR_I_rght = 1'b0; clr_fault = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_pwm_en", pwm_en, 1);
    chk("rst_fault_lft", fault_lft, 0);
    chk("rst_fault_rght", fault_rght, 0);
    chk("rst_trip_cnt", trip_cnt, 0);

    // Blanked pulses for 10 periods never count.
    synch(0);
    for (int i = 0; i < 10; i++) begin body(1, 0); synch(0); end
    chk("blank_pwm_en", pwm_en, 1);
    chk("blank_fault_lft", fault_lft, 0);
    chk("blank_trip_cnt", trip_cnt, 0);
    chk("blank_cnt_lft", dut.r_cnt_lft, 0);

    // Left trip after 4 qualifying periods.
    for (int i = 0; i < 3; i++) begin body(2, 0); synch(0); end
    chk("lft_cnt3", dut.r_cnt_lft, 3);
    body(2, 0);
    chk("lft_pre_trip_pwm_en", pwm_en, 1);
    synch(0);
    chk("lft_trip_pwm_en", pwm_en, 0);
    chk("lft_trip_fault_lft", fault_lft, 1);
    chk("lft_trip_fault_rght", fault_rght, 0);
    chk("lft_trip_cnt", trip_cnt, 1);
    body(2, 0);
    chk("lft_shutdown_hold", pwm_en, 0);
    clr_pulse();
    chk("lft_clr_pwm_en", pwm_en, 1);
    chk("lft_clr_fault_lft", fault_lft, 0);
    chk("lft_clr_cnt_lft", dut.r_cnt_lft, 0);
    synch(0);

    // Non-consecutive right periods: 3 hits, clean, 3 hits.
    for (int i = 0; i < 3; i++) begin body(0, 2); synch(0); end
    chk("nc_cnt3", dut.r_cnt_rght, 3);
    body(0, 0); synch(0);
    chk("nc_cnt_cleared", dut.r_cnt_rght, 0);
    for (int i = 0; i < 3; i++) begin body(0, 2); synch(0); end
    chk("nc_cnt3_again", dut.r_cnt_rght, 3);
    chk("nc_pwm_en", pwm_en, 1);
    chk("nc_fault_rght", fault_rght, 0);
    body(0, 0); synch(0);

    // Dual trip with clr_fault on the tripping synch: the trip wins.
    for (int i = 0; i < 4; i++) begin
      body(2, 2);
      synch(i == 3);
    end
    chk("dual_pwm_en", pwm_en, 0);
    chk("dual_fault_lft", fault_lft, 1);
    chk("dual_fault_rght", fault_rght, 1);
    chk("dual_trip_cnt", trip_cnt, 2);
    tick(); tick();
    clr_pulse();
    chk("dual_clr_pwm_en", pwm_en, 1);
    chk("dual_clr_fault_lft", fault_lft, 0);
    chk("dual_clr_fault_rght", fault_rght, 0);
    chk("dual_clr_trip_cnt", trip_cnt, 2);
    synch(0);

    // Reset while shut down.
    for (int i = 0; i < 4; i++) begin body(2, 0); synch(0); end
    chk("rsd_tripped", pwm_en, 0);
    chk("rsd_trip_cnt", trip_cnt, 3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rsd_pwm_en", pwm_en, 1);
    chk("rsd_fault_lft", fault_lft, 0);
    chk("rsd_trip_cnt0", trip_cnt, 0);

    // Trip, then 8 quiet periods: auto-retry returns to run only if built in.
    synch(0);
    for (int i = 0; i < 4; i++) begin body(2, 0); synch(0); end
    chk("rty_tripped", pwm_en, 0);
    for (int i = 0; i < 7; i++) begin body(0, 0); synch(0); end
    chk("rty_before_8th", pwm_en, 0);
    body(0, 0); synch(0);
`ifdef OVR_I_AUTO_RETRY_EN
    chk("rty_after_8th", pwm_en, 1);
`else
    chk("rty_after_8th", pwm_en, 0);
`endif
    chk("rty_fault_lft", fault_lft, 1);
    chk("rty_trip_cnt", trip_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ovr_i_fault_mon.md
Name: ovr_i_fault_mon

Overview:
- Over-current fault monitor in the motor-drive path, directly upstream of the PWM output gating in the drive block.
- Synchronizes the raw OVR_I_lft/OVR_I_rght comparator flags and ignores them during the PWM blanking window.
- Counts PWM periods that contain a qualified over-current event and latches a shutdown that forces all four PWM outputs low.
- Shutdown persists until explicitly cleared or reset.

Parameters:
- TRIP_PERIODS, 4: number of consecutive PWM periods with a qualified over-current on one side needed to trip (range 1..15).
- CNT_W, 4: width of each per-side consecutive-period counter.
- RETRY_PERIODS, 1024: PWM periods spent in shutdown before auto-retry (used only with OVR_I_AUTO_RETRY_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- PWM_synch  in  1  one-cycle pulse marking the start of each PWM period
- ovr_I_blank  in  1  high during the switching blanking window
- OVR_I_lft  in  1  raw asynchronous left over-current flag
- OVR_I_rght  in  1  raw asynchronous right over-current flag
- clr_fault  in  1  one-cycle request to leave shutdown
- pwm_en  out  1  1 = PWM outputs allowed, 0 = force all PWM low
- fault_lft  out  1  sticky: left side caused the trip
- fault_rght  out  1  sticky: right side caused the trip
- trip_cnt  out  8  saturating count of trips since reset

Behaviour:
- Synchronization:
  - OVR_I_lft and OVR_I_rght each pass through a 2-flop synchronizer.
  - ovr_I_blank is delayed 2 flops so it stays aligned with the synchronized flags.
- Qualified event: synchronized OVR high while delayed blank is low.
  - Each qualified event sets the per-side seen_x flag for the current period.
- Period close, on a cycle with PWM_synch = 1:
  - If seen_x (including an event in that same cycle): cnt_x increments, saturating at 2^CNT_W-1.
  - Otherwise cnt_x clears to 0.
  - seen_x then clears to 0 for the new period.
- Trip condition: in state RUN, an updated cnt_x >= TRIP_PERIODS.
  - Trip evaluation uses the updated counter value, registered.
  - pwm_en falls exactly 1 clk after the PWM_synch that closes the tripping period.
- States:
  - RUN, reset state: pwm_en = 1.
    - On trip: go to SHUTDOWN; set fault_lft and/or fault_rght (both when both trip in the same cycle); increment trip_cnt (saturates at 255).
  - SHUTDOWN: pwm_en = 0. Counters and seen flags are held at 0, so over-current input is ignored.
    - clr_fault = 1: go to RUN next cycle, clearing fault_lft/fault_rght and both counters.
- Simultaneous events: clr_fault in the same cycle as a trip in RUN has no effect; the trip wins.
- Reset values: pwm_en = 1, fault_lft = 0, fault_rght = 0, trip_cnt = 0, counters = 0, seen = 0, synchronizer flops = 0, state = RUN.
- Reset mid-shutdown returns to RUN on the next clk with all of the above values.
- Events are blanked using only the delayed blank. A pulse entirely inside the blank window never counts.
- Periods are defined only by PWM_synch. With no PWM_synch, counters hold and seen stays set.

Optional Feature:
- Macro: OVR_I_AUTO_RETRY_EN.
- When defined:
  - Adds state RETRY_WAIT in place of SHUTDOWN, with a retry counter of clog2(RETRY_PERIODS+1) bits.
  - Each PWM_synch in RETRY_WAIT increments the retry counter. On reaching RETRY_PERIODS, the block returns to RUN with counters cleared.
  - fault_lft/fault_rght stay sticky until clr_fault.
  - clr_fault in RETRY_WAIT returns to RUN immediately, as in SHUTDOWN.
- When undefined: no retry logic; SHUTDOWN exits only via clr_fault or rst.

Test Plan:
- Blanked pulse: assert OVR_I_lft for 45 clks fully inside the ovr_I_blank window, every period for 10 periods -> pwm_en stays 1, fault_lft = 0, trip_cnt = 0.
- Left trip: OVR_I_lft high 45 clks outside blank in 4 consecutive periods -> pwm_en = 0 one clk after the 4th closing PWM_synch, fault_lft = 1, fault_rght = 0, trip_cnt = 1.
- Non-consecutive: OVR_I_rght outside blank in periods 1,2,3, clean period 4, then periods 5,6,7 -> no trip, cnt_rght back to 0 after period 4, pwm_en = 1.
- Dual trip plus clear race: both sides qualify 4 periods and clr_fault pulses on the trip cycle -> SHUTDOWN, fault_lft = fault_rght = 1, trip_cnt = 1. A later clr_fault gives pwm_en = 1 and both faults 0 on the next clk.
- Reset mid-shutdown: trip, then pulse rst for 1 clk -> next cycle pwm_en = 1, faults 0, trip_cnt = 0.
- OVR_I_AUTO_RETRY_EN with RETRY_PERIODS = 8: trip, hold OVR low -> pwm_en returns to 1 one clk after the 8th PWM_synch in RETRY_WAIT, and fault_lft remains 1.
